// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU with tag sideband; define ALU_PIPE_FLAGS_EN to add flag_z/n/c/v outputs
module alu_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_ctrl,
  input  logic [DATA_WIDTH-1:0] in0,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out,
`ifdef ALU_PIPE_FLAGS_EN
  output logic                  flag_z,
  output logic                  flag_n,
  output logic                  flag_c,
  output logic                  flag_v,
`endif
  output logic [TAG_WIDTH-1:0]  out_tag
);
  localparam int M = DATA_WIDTH - 1;
  logic                  s1_v;
  logic [2:0]            s1_ctrl;
  logic [DATA_WIDTH-1:0] s1_a, s1_b, res;
  logic [TAG_WIDTH-1:0]  s1_tag;
  logic                  s2_adv;
  assign s2_adv   = out_ready || !out_valid;
  assign in_ready = !s1_v || s2_adv;
`ifdef ALU_PIPE_FLAGS_EN
  logic [DATA_WIDTH:0] sum_w, dif_w;
  logic                c_nxt, v_nxt;
  assign sum_w = {1'b0, s1_a} + {1'b0, s1_b};
  assign dif_w = {1'b0, s1_a} - {1'b0, s1_b};
  // carry/borrow-free and signed overflow only mean something for ADD and SUB
  always_comb begin
    c_nxt = s1_ctrl == 3'd0 ? sum_w[DATA_WIDTH] : s1_ctrl == 3'd1 ? !dif_w[DATA_WIDTH] : 1'b0;
    v_nxt = s1_ctrl == 3'd0 ? (s1_a[M] == s1_b[M]) && (sum_w[M] != s1_a[M]) :
            s1_ctrl == 3'd1 ? (s1_a[M] != s1_b[M]) && (dif_w[M] != s1_a[M]) : 1'b0;
  end
`else
  logic [DATA_WIDTH-1:0] sum_w, dif_w;
  assign sum_w = s1_a + s1_b;
  assign dif_w = s1_a - s1_b;
`endif
  // opcode decode of the S1 operation into the S2 result
  always_comb begin
    res = s1_a;
    case (s1_ctrl)
      3'd0: res = sum_w[M:0];
      3'd1: res = dif_w[M:0];
      3'd2: res = s1_a & s1_b;
      3'd3: res = s1_a | s1_b;
      3'd4: res = s1_a ^ s1_b;
      3'd5: res = {{M{1'b0}}, s1_a == s1_b};
      3'd6: res = {{M{1'b0}}, $signed(s1_a) < $signed(s1_b)};
      default: res = s1_a;
    endcase
  end
  // S1: take a new operation whenever the stage is free or draining into S2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_ctrl <= '0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_tag  <= '0;
    end else if (in_ready) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_ctrl <= in_ctrl;
        s1_a    <= in0;
        s1_b    <= in1;
        s1_tag  <= in_tag;
      end
    end
  end
  // S2: results hold while the consumer stalls; empty stages keep stale data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_tag   <= '0;
`ifdef ALU_PIPE_FLAGS_EN
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
`endif
    end else if (s2_adv) begin
      out_valid <= s1_v;
      if (s1_v) begin
        out     <= res;
        out_tag <= s1_tag;
`ifdef ALU_PIPE_FLAGS_EN
        flag_z  <= res == '0;
        flag_n  <= res[M];
        flag_c  <= c_nxt;
        flag_v  <= v_nxt;
`endif
      end
    end
  end
endmodule
